// File: rtl/pipeline_pkg.sv
// Shared types and constants for the decode/execute issue path.
package pipeline_pkg;

  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } haz_state_t;

  typedef enum logic [1:0] {
    ReasonNone = 2'd0,
    ReasonRaw  = 2'd1,
    ReasonWaw  = 2'd2,
    ReasonFull = 2'd3
  } stall_reason_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write bitmap with set/clear/clear-all and a same-cycle clear bypass on three lookups.
module reg_scoreboard
  import pipeline_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic                 clr_all,
  input  logic [REG_IDX_W-1:0] idx_a,
  input  logic [REG_IDX_W-1:0] idx_b,
  input  logic [REG_IDX_W-1:0] idx_c,
  output logic                 eff_a,
  output logic                 eff_b,
  output logic                 eff_c,
  output logic [NUM_REGS-1:0]  pending
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] eff;

  // Bit 0 is never set, so lookups of register 0 always read as clear.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      set_mask[i] = set_en && (set_idx == REG_IDX_W'(i));
      clr_mask[i] = clr_en && (clr_idx == REG_IDX_W'(i));
    end
    eff       = pending_q & ~clr_mask;
    pending_d = eff | set_mask;
  end

  always_ff @(posedge clk) begin
    if (reset || clr_all) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign eff_a   = eff[idx_a];
  assign eff_b   = eff[idx_b];
  assign eff_c   = eff[idx_c];
  assign pending = pending_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Issue gate between decode and execute: RAW/WAW/capacity hazards plus a fixed flush window.
// Define PIPE_HAZ_PERF_EN to add the stall_cycles performance counter port.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               dec_valid,
  input  logic [REG_IDX_W-1:0]               r1_reg,
  input  logic [REG_IDX_W-1:0]               r2_reg,
  input  logic [REG_IDX_W-1:0]               dst_reg,
  input  logic                               uses_r1,
  input  logic                               uses_r2,
  input  logic                               writes_dst,
  input  logic                               ex_ready,
  input  logic                               wb_valid,
  input  logic [REG_IDX_W-1:0]               wb_reg,
  input  logic                               flush,
  output logic                               issue_ready,
  output logic                               issue_fire,
  output logic [1:0]                         stall_reason,
  output logic [NUM_REGS-1:0]                pending_mask,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_cnt
`ifdef PIPE_HAZ_PERF_EN
  ,
  output logic [31:0]                        stall_cycles
`endif
);

  localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned FcW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_INFLIGHT);
  localparam logic [FcW-1:0]  FcLast = FcW'(FLUSH_CYCLES - 1);

  haz_state_t      state_q;
  logic [FcW-1:0]  flush_cnt_q;
  logic [CntW-1:0] inflight_q;

  logic          eff_r1, eff_r2, eff_dst;
  logic          dst_live, raw, waw, full, hazard;
  logic          flushing, clear_all, count_set;
  stall_reason_t reason;

  assign flushing  = (state_q == StFlush);
  assign dst_live  = writes_dst && (dst_reg != '0);
  assign raw       = (uses_r1 && eff_r1) || (uses_r2 && eff_r2);
  assign waw       = writes_dst && eff_dst;
  // A writeback this cycle frees a slot, so capacity never blocks alongside it.
  assign full      = dst_live && (inflight_q == CntMax) && !wb_valid;
  assign hazard    = raw || waw || full;

  assign issue_ready = !flushing && !flush && ex_ready && !hazard;
  assign issue_fire  = dec_valid && issue_ready;
  assign count_set   = issue_fire && dst_live;
  assign clear_all   = flush || flushing;

  always_comb begin
    reason = ReasonNone;
    if (dec_valid && !flushing) begin
      if (raw) begin
        reason = ReasonRaw;
      end else if (waw) begin
        reason = ReasonWaw;
      end else if (full) begin
        reason = ReasonFull;
      end
    end
  end

  assign stall_reason = reason;

  reg_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (count_set),
    .set_idx (dst_reg),
    .clr_en  (wb_valid),
    .clr_idx (wb_reg),
    .clr_all (clear_all),
    .idx_a   (r1_reg),
    .idx_b   (r2_reg),
    .idx_c   (dst_reg),
    .eff_a   (eff_r1),
    .eff_b   (eff_r2),
    .eff_c   (eff_dst),
    .pending (pending_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
      inflight_q  <= '0;
    end else if (flush) begin
      state_q     <= StFlush;
      flush_cnt_q <= '0;
      inflight_q  <= '0;
    end else begin
      case (state_q)
        StRun, StStall: begin
          state_q <= (dec_valid && hazard) ? StStall : StRun;
          if (count_set && !wb_valid) begin
            inflight_q <= inflight_q + 1'b1;
          end else if (!count_set && wb_valid && (inflight_q != '0)) begin
            inflight_q <= inflight_q - 1'b1;
          end
        end
        StFlush: begin
          // Writebacks of squashed work are dropped for the whole window.
          inflight_q <= '0;
          if (flush_cnt_q == FcLast) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q     <= StRun;
          flush_cnt_q <= '0;
          inflight_q  <= '0;
        end
      endcase
    end
  end

  assign inflight_cnt = inflight_q;

`ifdef PIPE_HAZ_PERF_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else if (dec_valid && !issue_ready) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard-driven directed bench for pipeline_hazard_ctrl (default parameters).
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [4:0]  r1_reg, r2_reg, dst_reg, wb_reg;
  logic        uses_r1, uses_r2, writes_dst;
  logic        ex_ready, wb_valid, flush;
  logic        issue_ready, issue_fire;
  logic [1:0]  stall_reason;
  logic [31:0] pending_mask;
  logic [2:0]  inflight_cnt;
`ifdef PIPE_HAZ_PERF_EN
  logic [31:0] stall_cycles;
`endif

  localparam int SelReady  = 0;
  localparam int SelFire   = 1;
  localparam int SelReason = 2;
  localparam int SelMask   = 3;
  localparam int SelCnt    = 4;
  localparam int SelPerf   = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   exp_stall = 0;

  pipeline_hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .r1_reg       (r1_reg),
    .r2_reg       (r2_reg),
    .dst_reg      (dst_reg),
    .uses_r1      (uses_r1),
    .uses_r2      (uses_r2),
    .writes_dst   (writes_dst),
    .ex_ready     (ex_ready),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .flush        (flush),
    .issue_ready  (issue_ready),
    .issue_fire   (issue_fire),
    .stall_reason (stall_reason),
    .pending_mask (pending_mask),
    .inflight_cnt (inflight_cnt)
`ifdef PIPE_HAZ_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SelReady:  return 32'(issue_ready);
      SelFire:   return 32'(issue_fire);
      SelReason: return 32'(stall_reason);
      SelMask:   return pending_mask;
      SelCnt:    return 32'(inflight_cnt);
`ifdef PIPE_HAZ_PERF_EN
      SelPerf:   return stall_cycles;
`endif
      default:   return 32'hdead_beef;
    endcase
  endfunction

  // Every cycle expected to stall with dec_valid high pushes a ready=0 entry; that feeds the perf count.
  task automatic push_exp(input string tag, input int sel, input logic [31:0] val);
    sb_q.push_back('{tag, sel, val});
    if (sel == SelReady && val == 32'd0 && dec_valid) exp_stall++;
  endtask

  task automatic tick();
    exp_t e;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    dec_valid  = 1'b0;
    r1_reg     = '0;
    r2_reg     = '0;
    dst_reg    = '0;
    uses_r1    = 1'b0;
    uses_r2    = 1'b0;
    writes_dst = 1'b0;
    ex_ready   = 1'b1;
    wb_valid   = 1'b0;
    wb_reg     = '0;
    flush      = 1'b0;
  endtask

  task automatic issue_dst(input logic [4:0] dst);
    set_idle();
    dec_valid  = 1'b1;
    writes_dst = 1'b1;
    dst_reg    = dst;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_idle();
    reset     = 1'b1;
    dec_valid = 1'b1;
    r1_reg    = 5'd3;
    uses_r1   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_exp("rst_fire", SelFire, 1);
    push_exp("rst_ready", SelReady, 1);
    push_exp("rst_reason", SelReason, 0);
    push_exp("rst_mask", SelMask, 0);
    push_exp("rst_cnt", SelCnt, 0);
`ifdef PIPE_HAZ_PERF_EN
    push_exp("rst_perf", SelPerf, 0);
`endif
    tick();

    // RAW stall on r1=5 until writeback of 5 bypasses it.
    issue_dst(5'd5);
    push_exp("raw_first_fire", SelFire, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      set_idle();
      dec_valid = 1'b1;
      uses_r1   = 1'b1;
      r1_reg    = 5'd5;
      if (i == 0) begin
        push_exp("raw_mask", SelMask, 32'h20);
        push_exp("raw_cnt", SelCnt, 1);
      end
      push_exp("raw_reason", SelReason, 1);
      push_exp("raw_ready", SelReady, 0);
      push_exp("raw_fire", SelFire, 0);
      tick();
    end
    wb_valid = 1'b1;
    wb_reg   = 5'd5;
    push_exp("raw_wb_ready", SelReady, 1);
    push_exp("raw_wb_fire", SelFire, 1);
    push_exp("raw_wb_reason", SelReason, 0);
    tick();
    set_idle();
    push_exp("raw_clr_mask", SelMask, 0);
    push_exp("raw_clr_cnt", SelCnt, 0);
    tick();

    // Destination 0 is never tracked.
    for (int i = 0; i < 4; i++) begin
      issue_dst(5'd0);
      push_exp("zero_fire", SelFire, 1);
      push_exp("zero_reason", SelReason, 0);
      push_exp("zero_mask", SelMask, 0);
      push_exp("zero_cnt", SelCnt, 0);
      tick();
    end

    // Capacity: four outstanding writes, then FULL.
    for (int k = 1; k <= 4; k++) begin
      issue_dst(5'(k));
      push_exp("cap_fire", SelFire, 1);
      push_exp("cap_cnt", SelCnt, 32'(k - 1));
      tick();
    end
    issue_dst(5'd5);
    push_exp("full_mask", SelMask, 32'h1e);
    push_exp("full_cnt", SelCnt, 4);
    push_exp("full_reason", SelReason, 3);
    push_exp("full_ready", SelReady, 0);
    tick();
    issue_dst(5'd0);
    push_exp("full_dst0_fire", SelFire, 1);
    tick();
    issue_dst(5'd3);
    push_exp("waw_reason", SelReason, 2);
    push_exp("waw_ready", SelReady, 0);
    tick();
    issue_dst(5'd3);
    uses_r1 = 1'b1;
    r1_reg  = 5'd2;
    push_exp("raw_over_waw", SelReason, 1);
    push_exp("raw_over_waw_ready", SelReady, 0);
    tick();
    set_idle();
    dec_valid = 1'b1;
    uses_r2   = 1'b1;
    r2_reg    = 5'd4;
    push_exp("raw_r2_reason", SelReason, 1);
    push_exp("raw_r2_ready", SelReady, 0);
    tick();
    issue_dst(5'd5);
    wb_valid = 1'b1;
    wb_reg   = 5'd1;
    push_exp("full_wb_reason", SelReason, 0);
    push_exp("full_wb_fire", SelFire, 1);
    tick();
    set_idle();
    push_exp("full_wb_cnt", SelCnt, 4);
    push_exp("full_wb_mask", SelMask, 32'h3c);
    tick();
    for (int k = 2; k <= 5; k++) begin
      set_idle();
      wb_valid = 1'b1;
      wb_reg   = 5'(k);
      tick();
    end
    set_idle();
    wb_valid = 1'b1;
    wb_reg   = 5'd9;
    push_exp("drain_mask", SelMask, 0);
    push_exp("drain_cnt", SelCnt, 0);
    tick();
    set_idle();
    push_exp("sat_cnt", SelCnt, 0);
    tick();

    // Backpressure alone blocks issue without a hazard reason.
    set_idle();
    dec_valid = 1'b1;
    ex_ready  = 1'b0;
    push_exp("bp_ready", SelReady, 0);
    push_exp("bp_fire", SelFire, 0);
    push_exp("bp_reason", SelReason, 0);
    tick();

    // Set wins over same-cycle clear of register 7.
    issue_dst(5'd7);
    push_exp("sw_first_fire", SelFire, 1);
    tick();
    issue_dst(5'd7);
    wb_valid = 1'b1;
    wb_reg   = 5'd7;
    push_exp("sw_pre_mask", SelMask, 32'h80);
    push_exp("sw_fire", SelFire, 1);
    push_exp("sw_reason", SelReason, 0);
    tick();
    set_idle();
    push_exp("sw_mask", SelMask, 32'h80);
    push_exp("sw_cnt", SelCnt, 1);
    tick();
    set_idle();
    wb_valid = 1'b1;
    wb_reg   = 5'd7;
    tick();
    set_idle();
    push_exp("sw_clr_mask", SelMask, 0);
    push_exp("sw_clr_cnt", SelCnt, 0);
    tick();

    // Flush window with mask 0x6 and two in flight.
    issue_dst(5'd1);
    tick();
    issue_dst(5'd2);
    tick();
    set_idle();
    dec_valid = 1'b1;
    flush     = 1'b1;
    push_exp("fl_pre_mask", SelMask, 32'h6);
    push_exp("fl_pre_cnt", SelCnt, 2);
    push_exp("fl_cycle_ready", SelReady, 0);
    push_exp("fl_cycle_fire", SelFire, 0);
    tick();
    set_idle();
    dec_valid = 1'b1;
    push_exp("fl_w0_ready", SelReady, 0);
    push_exp("fl_w0_reason", SelReason, 0);
    push_exp("fl_w0_mask", SelMask, 0);
    push_exp("fl_w0_cnt", SelCnt, 0);
    tick();
    set_idle();
    dec_valid = 1'b1;
    wb_valid  = 1'b1;
    wb_reg    = 5'd1;
    push_exp("fl_w1_ready", SelReady, 0);
    tick();
    set_idle();
    dec_valid = 1'b1;
    push_exp("fl_end_ready", SelReady, 1);
    push_exp("fl_end_fire", SelFire, 1);
    push_exp("fl_end_mask", SelMask, 0);
    push_exp("fl_end_cnt", SelCnt, 0);
`ifdef PIPE_HAZ_PERF_EN
    push_exp("perf_count", SelPerf, 32'(exp_stall));
`endif
    tick();

    // Flush inside the window restarts it.
    for (int i = 0; i < 5; i++) begin
      set_idle();
      dec_valid = 1'b1;
      flush     = (i == 0 || i == 2);
      push_exp("rs_ready", SelReady, 0);
      tick();
    end
    set_idle();
    dec_valid = 1'b1;
    push_exp("rs_end_ready", SelReady, 1);
    tick();

    // Reset in the middle of a flush window.
    issue_dst(5'd4);
    tick();
    set_idle();
    dec_valid = 1'b1;
    flush     = 1'b1;
    push_exp("rf_flush_ready", SelReady, 0);
    tick();
    set_idle();
    dec_valid = 1'b1;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    exp_stall = 0;
    push_exp("rf_ready", SelReady, 1);
    push_exp("rf_fire", SelFire, 1);
    push_exp("rf_mask", SelMask, 0);
    push_exp("rf_cnt", SelCnt, 0);
`ifdef PIPE_HAZ_PERF_EN
    push_exp("rf_perf", SelPerf, 32'(exp_stall));
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
